// File: rtl/pass_scheduler_if.sv
// rtl/pass_scheduler_if.sv - pass handshake and per-pass parameter bus between pass_scheduler and token_engine
interface pass_scheduler_if;
  logic        pass_start_o;
  logic        pass_done_i;
  logic [1:0]  layer_type_o;
  logic [31:0] weight_GLB_base_addr_o;
  logic [31:0] ifmap_GLB_base_addr_o;
  logic [31:0] ipsum_GLB_base_addr_o;
  logic [31:0] bias_GLB_base_addr_o;
  logic [31:0] opsum_GLB_base_addr_o;
  logic [31:0] tile_n_o;
  logic [31:0] On_real_o;
  logic        n_tile_is_first_o;
  logic        n_tile_is_last_o;
  logic [31:0] pass_idx_o;

  // Scheduler side: drives the pass bus, receives completion.
  modport master (
    output pass_start_o, layer_type_o,
    output weight_GLB_base_addr_o, ifmap_GLB_base_addr_o, ipsum_GLB_base_addr_o,
    output bias_GLB_base_addr_o, opsum_GLB_base_addr_o,
    output tile_n_o, On_real_o, n_tile_is_first_o, n_tile_is_last_o, pass_idx_o,
    input  pass_done_i
  );

  // Engine side: consumes the pass bus, reports completion.
  modport slave (
    input  pass_start_o, layer_type_o,
    input  weight_GLB_base_addr_o, ifmap_GLB_base_addr_o, ipsum_GLB_base_addr_o,
    input  bias_GLB_base_addr_o, opsum_GLB_base_addr_o,
    input  tile_n_o, On_real_o, n_tile_is_first_o, n_tile_is_last_o, pass_idx_o,
    output pass_done_i
  );
endinterface

// File: rtl/pass_scheduler.sv
// rtl/pass_scheduler.sv - splits a layer into passes and sequences them toward token_engine
module pass_scheduler #(
  parameter int DW_HALO = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             layer_start_i,
  input  logic [1:0]       layer_type_i,
  input  logic [31:0]      on_total_i,
  input  logic [31:0]      tile_n_cfg_i,
  input  logic [31:0]      weight_base_i,
  input  logic [31:0]      ifmap_base_i,
  input  logic [31:0]      ipsum_base_i,
  input  logic [31:0]      bias_base_i,
  input  logic [31:0]      opsum_base_i,
  input  logic [31:0]      ifmap_stride_i,
  input  logic [31:0]      ipsum_stride_i,
  input  logic [31:0]      opsum_stride_i,
  pass_scheduler_if.master pass_if,
  output logic             busy_o,
  output logic             layer_done_o,
  output logic             cfg_err_o
);

  localparam logic [1:0] DEPTHWISE = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched layer configuration
  logic [1:0]  type_q;
  logic [31:0] tile_cfg_q;
  logic [31:0] weight_base_q, bias_base_q;
  logic [31:0] ifmap_stride_q, ipsum_stride_q, opsum_stride_q;
  logic        err_q;

  // Running pass bookkeeping; accumulators hold base + pass_idx * stride
  logic [31:0] remaining_q, pass_idx_q;
  logic [31:0] ifmap_acc_q, ipsum_acc_q, opsum_acc_q;

  // Registered pass outputs, loaded in SETUP and held until the next SETUP
  logic [31:0] on_real_q, tile_n_q, pass_idx_out_q;
  logic [31:0] weight_addr_q, ifmap_addr_q, ipsum_addr_q, bias_addr_q, opsum_addr_q;
  logic        first_q, last_q;

  logic [31:0] on_real_d, tile_n_d;
  logic        last_d;
  logic        zero_work;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; pass_done is only honoured in WAIT
  always_comb begin
    state_d   = state_q;
    zero_work = (on_total_i == 32'd0) || (tile_n_cfg_i == 32'd0);
    case (state_q)
      S_IDLE:  if (layer_start_i) state_d = zero_work ? S_DONE : S_SETUP;
      S_SETUP: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (pass_if.pass_done_i) state_d = last_q ? S_DONE : S_SETUP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded strobes and status
  always_comb begin
    pass_if.pass_start_o = (state_q == S_START);
    layer_done_o         = (state_q == S_DONE);
    cfg_err_o            = (state_q == S_DONE) && err_q;
    busy_o               = (state_q != S_IDLE);
  end

  // Geometry of the pass about to be issued
  always_comb begin
    on_real_d = (remaining_q < tile_cfg_q) ? remaining_q : tile_cfg_q;
    tile_n_d  = (type_q == DEPTHWISE) ? (on_real_d + 32'(DW_HALO)) : on_real_d;
    last_d    = (remaining_q <= tile_cfg_q);
  end

  // Config latch at layer start and per-pass stepping after a non-last pass completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q         <= 2'd0;
      tile_cfg_q     <= '0;
      weight_base_q  <= '0;
      bias_base_q    <= '0;
      ifmap_stride_q <= '0;
      ipsum_stride_q <= '0;
      opsum_stride_q <= '0;
      err_q          <= 1'b0;
      remaining_q    <= '0;
      pass_idx_q     <= '0;
      ifmap_acc_q    <= '0;
      ipsum_acc_q    <= '0;
      opsum_acc_q    <= '0;
    end else if (state_q == S_IDLE && layer_start_i) begin
      type_q         <= layer_type_i;
      tile_cfg_q     <= tile_n_cfg_i;
      weight_base_q  <= weight_base_i;
      bias_base_q    <= bias_base_i;
      ifmap_stride_q <= ifmap_stride_i;
      ipsum_stride_q <= ipsum_stride_i;
      opsum_stride_q <= opsum_stride_i;
      err_q          <= (tile_n_cfg_i == 32'd0);
      remaining_q    <= on_total_i;
      pass_idx_q     <= '0;
      ifmap_acc_q    <= ifmap_base_i;
      ipsum_acc_q    <= ipsum_base_i;
      opsum_acc_q    <= opsum_base_i;
    end else if (state_q == S_WAIT && pass_if.pass_done_i && !last_q) begin
      remaining_q    <= remaining_q - on_real_q;
      pass_idx_q     <= pass_idx_q + 32'd1;
      ifmap_acc_q    <= ifmap_acc_q + ifmap_stride_q;
      ipsum_acc_q    <= ipsum_acc_q + ipsum_stride_q;
      opsum_acc_q    <= opsum_acc_q + opsum_stride_q;
    end
  end

  // Pass output registers, loaded once per pass in SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_real_q      <= '0;
      tile_n_q       <= '0;
      pass_idx_out_q <= '0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      weight_addr_q  <= '0;
      ifmap_addr_q   <= '0;
      ipsum_addr_q   <= '0;
      bias_addr_q    <= '0;
      opsum_addr_q   <= '0;
    end else if (state_q == S_SETUP) begin
      on_real_q      <= on_real_d;
      tile_n_q       <= tile_n_d;
      pass_idx_out_q <= pass_idx_q;
      first_q        <= (pass_idx_q == 32'd0);
      last_q         <= last_d;
      weight_addr_q  <= weight_base_q;
      ifmap_addr_q   <= ifmap_acc_q;
      ipsum_addr_q   <= ipsum_acc_q;
      bias_addr_q    <= bias_base_q;
      opsum_addr_q   <= opsum_acc_q;
    end
  end

  assign pass_if.layer_type_o           = type_q;
  assign pass_if.weight_GLB_base_addr_o = weight_addr_q;
  assign pass_if.ifmap_GLB_base_addr_o  = ifmap_addr_q;
  assign pass_if.ipsum_GLB_base_addr_o  = ipsum_addr_q;
  assign pass_if.bias_GLB_base_addr_o   = bias_addr_q;
  assign pass_if.opsum_GLB_base_addr_o  = opsum_addr_q;
  assign pass_if.tile_n_o               = tile_n_q;
  assign pass_if.On_real_o              = on_real_q;
  assign pass_if.n_tile_is_first_o      = first_q;
  assign pass_if.n_tile_is_last_o       = last_q;
  assign pass_if.pass_idx_o             = pass_idx_out_q;

endmodule

// File: tb/tb_pass_scheduler.sv
// tb/tb_pass_scheduler.sv - scoreboard bench for pass_scheduler
module tb_pass_scheduler;
  localparam logic [1:0] PW = 2'd0;
  localparam logic [1:0] DW = 2'd1;

  logic        clk, rst_n;
  logic        layer_start;
  logic [1:0]  layer_type;
  logic [31:0] on_total, tile_cfg;
  logic [31:0] weight_base, ifmap_base, ipsum_base, bias_base, opsum_base;
  logic [31:0] ifmap_stride, ipsum_stride, opsum_stride;
  logic        busy, layer_done, cfg_err;
  logic        man_done, auto_pulse, auto_done;

  pass_scheduler_if pif ();
  assign pif.pass_done_i = man_done | auto_pulse;

  pass_scheduler #(.DW_HALO(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .layer_start_i  (layer_start),
    .layer_type_i   (layer_type),
    .on_total_i     (on_total),
    .tile_n_cfg_i   (tile_cfg),
    .weight_base_i  (weight_base),
    .ifmap_base_i   (ifmap_base),
    .ipsum_base_i   (ipsum_base),
    .bias_base_i    (bias_base),
    .opsum_base_i   (opsum_base),
    .ifmap_stride_i (ifmap_stride),
    .ipsum_stride_i (ipsum_stride),
    .opsum_stride_i (opsum_stride),
    .pass_if        (pif),
    .busy_o         (busy),
    .layer_done_o   (layer_done),
    .cfg_err_o      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] idx, on_real, tile_n, ifmap, ipsum, opsum;
    logic        first, last;
  } pass_exp_t;

  pass_exp_t exp_q[$];
  logic      done_q[$];
  int        n_chk = 0, n_fail = 0, n_starts = 0, n_dones = 0;
  logic [1:0] cur_type;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pass(input int idx, input int onr, input int tn, input logic f, input logic l,
                           input logic [31:0] ia, input logic [31:0] pa, input logic [31:0] oa);
    pass_exp_t e;
    e.idx = idx; e.on_real = onr; e.tile_n = tn; e.first = f; e.last = l;
    e.ifmap = ia; e.ipsum = pa; e.opsum = oa;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every pass_start and layer_done
  always @(negedge clk) begin
    pass_exp_t e;
    if (rst_n) begin
      if (pif.pass_start_o) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pass_start pass_idx=%0d expected=none", pif.pass_idx_o);
        end else begin
          e = exp_q.pop_front();
          chk("pass_idx", pif.pass_idx_o, e.idx);
          chk("On_real", pif.On_real_o, e.on_real);
          chk("tile_n", pif.tile_n_o, e.tile_n);
          chk("first", 32'(pif.n_tile_is_first_o), 32'(e.first));
          chk("last", 32'(pif.n_tile_is_last_o), 32'(e.last));
          chk("ifmap_addr", pif.ifmap_GLB_base_addr_o, e.ifmap);
          chk("ipsum_addr", pif.ipsum_GLB_base_addr_o, e.ipsum);
          chk("opsum_addr", pif.opsum_GLB_base_addr_o, e.opsum);
          chk("weight_addr", pif.weight_GLB_base_addr_o, 32'hA000);
          chk("bias_addr", pif.bias_GLB_base_addr_o, 32'hB000);
          chk("layer_type", 32'(pif.layer_type_o), 32'(cur_type));
        end
      end
      if (layer_done) begin
        n_dones++;
        if (done_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_layer_done actual=1 expected=0");
        end else begin
          chk("cfg_err", 32'(cfg_err), 32'(done_q.pop_front()));
        end
      end else if (cfg_err) begin
        n_chk++; n_fail++;
        $display("FAIL cfg_err_without_done actual=1 expected=0");
      end
    end
  end

  // Token-engine stand-in: pass_done 20 cycles after each start
  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_done && rst_n && pif.pass_start_o) begin
        repeat (20) @(negedge clk);
        if (auto_done && rst_n) begin
          auto_pulse = 1'b1;
          @(negedge clk);
          auto_pulse = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic start_layer(input logic [1:0] t, input logic [31:0] ont, input logic [31:0] tc);
    @(negedge clk);
    layer_type = t; on_total = ont; tile_cfg = tc; cur_type = t;
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
  endtask

  task automatic wait_done(input int snap, input string name);
    int c = 0;
    while (n_dones == snap && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(n_dones - snap), 32'd1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_pass_start"}, 32'(pif.pass_start_o), 0);
    chk({p, "_layer_type"}, 32'(pif.layer_type_o), 0);
    chk({p, "_weight"}, pif.weight_GLB_base_addr_o, 0);
    chk({p, "_ifmap"}, pif.ifmap_GLB_base_addr_o, 0);
    chk({p, "_ipsum"}, pif.ipsum_GLB_base_addr_o, 0);
    chk({p, "_bias"}, pif.bias_GLB_base_addr_o, 0);
    chk({p, "_opsum"}, pif.opsum_GLB_base_addr_o, 0);
    chk({p, "_tile_n"}, pif.tile_n_o, 0);
    chk({p, "_On_real"}, pif.On_real_o, 0);
    chk({p, "_first"}, 32'(pif.n_tile_is_first_o), 0);
    chk({p, "_last"}, 32'(pif.n_tile_is_last_o), 0);
    chk({p, "_pass_idx"}, pif.pass_idx_o, 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_layer_done"}, 32'(layer_done), 0);
    chk({p, "_cfg_err"}, 32'(cfg_err), 0);
  endtask

  task automatic push_pw100();
    push_pass(0, 40, 40, 1, 0, 32'h1000, 32'h2000, 32'h3000);
    push_pass(1, 40, 40, 0, 0, 32'h1280, 32'h2100, 32'h3A00);
    push_pass(2, 20, 20, 0, 1, 32'h1500, 32'h2200, 32'h4400);
  endtask

  initial begin
    int s0, d0, c;
    rst_n = 1'b0; layer_start = 1'b0; layer_type = PW; cur_type = PW;
    on_total = 0; tile_cfg = 0; man_done = 1'b0; auto_done = 1'b0;
    weight_base = 32'hA000; bias_base = 32'hB000;
    ifmap_base = 32'h1000; ifmap_stride = 32'h280;
    ipsum_base = 32'h2000; ipsum_stride = 32'h100;
    opsum_base = 32'h3000; opsum_stride = 32'hA00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Pointwise 100 / 40 with start latency check
    auto_done = 1'b1;
    push_pw100(); done_q.push_back(1'b0);
    s0 = n_starts; d0 = n_dones;
    start_layer(PW, 100, 40);
    chk("pw_busy_after_start", 32'(busy), 1);
    chk("pw_no_start_in_setup", 32'(pif.pass_start_o), 0);
    @(negedge clk);
    chk("pw_start_latency", 32'(pif.pass_start_o), 1);
    wait_done(d0, "pw_layer_done");
    chk("pw_pass_count", 32'(n_starts - s0), 3);
    @(negedge clk);
    chk("pw_idle_busy", 32'(busy), 0);

    // Depthwise 4 / 2
    push_pass(0, 2, 4, 1, 0, 32'h1000, 32'h2000, 32'h3000);
    push_pass(1, 2, 4, 0, 1, 32'h1280, 32'h2100, 32'h3A00);
    done_q.push_back(1'b0);
    s0 = n_starts; d0 = n_dones;
    start_layer(DW, 4, 2);
    wait_done(d0, "dw_layer_done");
    chk("dw_pass_count", 32'(n_starts - s0), 2);

    // Exact multiple 80 / 40
    push_pass(0, 40, 40, 1, 0, 32'h1000, 32'h2000, 32'h3000);
    push_pass(1, 40, 40, 0, 1, 32'h1280, 32'h2100, 32'h3A00);
    done_q.push_back(1'b0);
    s0 = n_starts; d0 = n_dones;
    start_layer(PW, 80, 40);
    wait_done(d0, "exact_layer_done");
    repeat (5) @(negedge clk);
    chk("exact_pass_count", 32'(n_starts - s0), 2);

    // Zero on_total and zero tile config
    done_q.push_back(1'b0);
    s0 = n_starts; d0 = n_dones;
    start_layer(PW, 0, 40);
    chk("zero_total_done_t1", 32'(layer_done), 1);
    chk("zero_total_err", 32'(cfg_err), 0);
    repeat (3) @(negedge clk);
    chk("zero_total_starts", 32'(n_starts - s0), 0);
    done_q.push_back(1'b1);
    s0 = n_starts;
    start_layer(PW, 100, 0);
    chk("zero_tile_done_t1", 32'(layer_done), 1);
    chk("zero_tile_err", 32'(cfg_err), 1);
    repeat (3) @(negedge clk);
    chk("zero_tile_starts", 32'(n_starts - s0), 0);

    // Handshake abuse: done during START, layer_start during WAIT
    auto_done = 1'b0;
    push_pass(0, 40, 40, 1, 0, 32'h1000, 32'h2000, 32'h3000);
    push_pass(1, 40, 40, 0, 1, 32'h1280, 32'h2100, 32'h3A00);
    done_q.push_back(1'b0);
    s0 = n_starts; d0 = n_dones;
    start_layer(PW, 80, 40);
    c = 0;
    while (!pif.pass_start_o && c < 20) begin @(negedge clk); c++; end
    chk("abuse_start_seen", 32'(pif.pass_start_o), 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abuse_still_busy", 32'(busy), 1);
    chk("abuse_pass_idx_held", pif.pass_idx_o, 0);
    chk("abuse_no_advance", 32'(n_starts - s0), 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("abuse_advance", 32'(n_starts - s0), 2);
    chk("abuse_pass_idx_1", pif.pass_idx_o, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_done(d0, "abuse_layer_done");
    chk("abuse_pass_count", 32'(n_starts - s0), 2);

    // Reset in WAIT of pass 1, then restart from pass 0
    auto_done = 1'b1;
    push_pw100();
    s0 = n_starts;
    start_layer(PW, 100, 40);
    c = 0;
    while (n_starts - s0 < 2 && c < 200) begin @(negedge clk); c++; end
    chk("rst_reached_pass1", 32'(n_starts - s0), 2);
    auto_done = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midwait_reset");
    chk("rst_pending_passes", 32'(exp_q.size()), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    auto_done = 1'b1;
    push_pw100(); done_q.push_back(1'b0);
    s0 = n_starts; d0 = n_dones;
    start_layer(PW, 100, 40);
    wait_done(d0, "restart_layer_done");
    chk("restart_pass_count", 32'(n_starts - s0), 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_passes_empty", 32'(exp_q.size()), 0);
    chk("scoreboard_dones_empty", 32'(done_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pass_scheduler.md
# pass_scheduler

Layer-level pass sequencer sitting directly upstream of `token_engine`. Splits one layer's output workload into passes of at most `tile_n_cfg_i` output units and computes per-pass GLB base addresses, `tile_n`, `On_real` and first/last flags. Pulses `pass_start_o`, then waits for `pass_done_i` before issuing the next pass. Geometry fields (`in_C`, `in_R`, `pad_*`, `out_C`, `out_R`, `IC_real`, `OC_real`, `is_bias`) are not touched here; they are wired straight from layer config to `token_engine`.

## Interface
Parameters:
- `DW_HALO`, default 2: extra input rows per depthwise pass (3x3 kernel).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `layer_start_i`, input, 1: start-of-layer pulse, sampled in IDLE only.
- `layer_type_i`, input, 2: `POINTWISE` or `DEPTHWISE` code.
- `on_total_i`, input, 32: total output units for the layer (pixels for pointwise, rows for depthwise).
- `tile_n_cfg_i`, input, 32: maximum output units per pass.
- `weight_base_i`, `ifmap_base_i`, `ipsum_base_i`, `bias_base_i`, `opsum_base_i`, input, 32 each: layer base addresses.
- `ifmap_stride_i`, `ipsum_stride_i`, `opsum_stride_i`, input, 32 each: per-pass address increments.
- `pass_done_i`, input, 1: from `token_engine.pass_done_o`.
- `pass_start_o`, output, 1: one-cycle pulse to `token_engine.pass_start_i`.
- `layer_type_o`, output, 2: latched layer type.
- `weight_GLB_base_addr_o`, `ifmap_GLB_base_addr_o`, `ipsum_GLB_base_addr_o`, `bias_GLB_base_addr_o`, `opsum_GLB_base_addr_o`, output, 32 each: per-pass addresses.
- `tile_n_o`, output, 32: per-pass input tile size.
- `On_real_o`, output, 32: valid output units in this pass.
- `n_tile_is_first_o`, `n_tile_is_last_o`, output, 1 each: pass position flags.
- `pass_idx_o`, output, 32: current pass index, starting at 0.
- `busy_o`, output, 1: high in any state other than IDLE.
- `layer_done_o`, output, 1: one-cycle pulse at end of layer.
- `cfg_err_o`, output, 1: one-cycle pulse that accompanies `layer_done_o` when `tile_n_cfg_i` is 0.

## Operation
- States: IDLE, SETUP, START, WAIT, DONE.
- **IDLE**
  - On `layer_start_i`, latch all config inputs.
  - Set pass_idx to 0 and remaining to `on_total_i`, then go to SETUP.
  - If `on_total_i == 0` or `tile_n_cfg_i == 0`, go directly to DONE instead. `cfg_err_o` pulses in DONE only for the `tile_n_cfg_i == 0` case.
- **SETUP** (1 cycle): register the pass outputs.
  - `On_real = min(tile_n_cfg, remaining)`.
  - `tile_n = On_real` for pointwise, `On_real + DW_HALO` for depthwise.
  - `first = (pass_idx == 0)`.
  - `last = (remaining <= tile_n_cfg)`.
  - Address per buffer X: `X_base + pass_idx * X_stride`, computed as an accumulator (add the stride each pass, no multiplier).
  - Weight and bias addresses are constant across passes.
  - Then go to START.
- **START** (1 cycle): `pass_start_o = 1`, then go to WAIT.
- **WAIT**: hold until `pass_done_i`.
  - If last: go to DONE.
  - Otherwise: `remaining -= On_real`, `pass_idx += 1`, step the address accumulators, go to SETUP.
- **DONE** (1 cycle): `layer_done_o = 1`, then go to IDLE.
- Arithmetic: all unsigned 32-bit; addresses wrap mod 2^32.
- `pass_done_i` is ignored outside WAIT.
- `layer_start_i` is ignored while `busy_o` is high.
- All pass outputs stay stable from SETUP through the end of WAIT, and hold their last values in DONE and IDLE.

## Timing
- Reset: state IDLE. Every output is 0, including all addresses, flags, `busy_o`, `pass_start_o`, `layer_done_o` and `cfg_err_o`.
- `layer_start_i` high at edge t: `busy_o` rises after t, outputs are valid after t+1, and `pass_start_o` is high during cycle t+2 (until edge t+3).
- `pass_done_i` high at edge t in WAIT, non-last pass: next `pass_start_o` high during cycle t+2.
- `pass_done_i` high at edge t in WAIT, last pass: `layer_done_o` high during cycle t+1. `busy_o` falls after edge t+2.
- Zero-work layer: `layer_start_i` at edge t gives `layer_done_o` during cycle t+1 and no `pass_start_o`.
- `pass_done_i` and the `pass_start_o` cycle coinciding: `pass_done_i` is ignored; the block waits for a later `pass_done_i`.
- Asynchronous reset mid-WAIT: return to IDLE immediately, all outputs 0. The next `layer_start_i` restarts the layer from pass 0.

## Test plan
- **Pointwise split:** `on_total=100`, `tile_n_cfg=40`, `ifmap_base=0x1000`, `ifmap_stride=0x280`, `opsum_base=0x3000`, `opsum_stride=0xA00`, `pass_done_i` pulsed 20 cycles after each start.
  - Exactly 3 `pass_start_o` pulses.
  - `On_real`/`tile_n` per pass = 40/40, 40/40, 20/20.
  - `ifmap` addresses 0x1000, 0x1280, 0x1500; `opsum` addresses 0x3000, 0x3A00, 0x4400.
  - First flag only on pass 0, last flag only on pass 2.
  - One `layer_done_o` pulse.
- **Depthwise:** `on_total=4`, `tile_n_cfg=2`.
  - 2 passes, each with `On_real=2`, `tile_n=4`.
  - pass0 first=1/last=0; pass1 first=0/last=1.
- **Exact multiple:** `on_total=80`, `tile_n_cfg=40`.
  - 2 passes, last flag on pass 1, no third pass.
- **Degenerate config:**
  - `on_total=0`: `layer_done_o` at t+1, no start, `cfg_err_o=0`.
  - `tile_n_cfg=0`: `layer_done_o` and `cfg_err_o` both pulse at t+1, no start.
- **Handshake abuse:**
  - `pass_done_i` held high during START → ignored; a later pulse in WAIT advances.
  - `layer_start_i` pulsed in WAIT → no effect on pass count.
- **Reset mid-WAIT** of pass 1:
  - All outputs 0 immediately.
  - A fresh `layer_start_i` reissues pass 0 with base addresses.
